// File: rtl/minterm_scanner_pkg.sv
// Shared types and sizes for the minterm scanner: FSM state encoding and
// the vector/count widths that the interface and the top module agree on.
package minterm_scanner_pkg;

  localparam int NUM_VEC = 32;
  localparam int VEC_W   = 5;
  localparam int CNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/minterm_scanner_if.sv
// Signal bundle between the scanner and whatever drives it and supplies y_in.
// start is a one-cycle request with no ready: it is taken only when the
// scanner is in IDLE or DONE and silently dropped while busy is high.
interface minterm_scanner_if;
  import minterm_scanner_pkg::*;

  logic               start;
  logic               target;
  logic               y_in;
  logic [VEC_W-1:0]   abcde_out;
  logic               busy;
  logic               done;
  logic [NUM_VEC-1:0] mask;
  logic [CNT_W-1:0]   count;
  logic               first_valid;
  logic [VEC_W-1:0]   first_idx;
  state_t             dbg_state;

  modport slave (
    input  start, target, y_in,
    output abcde_out, busy, done, mask, count, first_valid, first_idx, dbg_state
  );

  modport master (
    output start, target, y_in,
    input  abcde_out, busy, done, mask, count, first_valid, first_idx, dbg_state
  );

endinterface

// File: rtl/minterm_scanner.sv
// Walks all 32 input vectors of an external 5-input expression, holding each
// for SETTLE_CYCLES+1 cycles and recording which ones give y_in == target.
module minterm_scanner
  import minterm_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  minterm_scanner_if.slave  bus
);

  state_t             state;
  logic [VEC_W-1:0]   idx;
  logic [3:0]         hold_cnt;
  logic [NUM_VEC-1:0] mask;
  logic [CNT_W-1:0]   count;
  logic               first_valid;
  logic [VEC_W-1:0]   first_idx;
  logic               tgt;
  logic               busy;
  logic               done;
  logic               last_hold;
  logic               match;

  assign last_hold = (hold_cnt == 4'(SETTLE_CYCLES));
  assign match     = (bus.y_in == tgt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      hold_cnt    <= '0;
      mask        <= '0;
      count       <= '0;
      first_valid <= 1'b0;
      first_idx   <= '0;
      tgt         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= HOLD;
            busy        <= 1'b1;
            idx         <= '0;
            hold_cnt    <= '0;
            mask        <= '0;
            count       <= '0;
            first_valid <= 1'b0;
            first_idx   <= '0;
            tgt         <= bus.target;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (last_hold) begin
            // y_in has had the full settle window on this vector; sample it.
            if (match) begin
              mask[idx] <= 1'b1;
              count     <= count + CNT_W'(1);
              if (!first_valid) begin
                first_valid <= 1'b1;
                first_idx   <= idx;
              end
            end
            if (idx == VEC_W'(NUM_VEC - 1)) begin
              // idx stays at 31 so the last vector remains on abcde_out.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx      <= idx + VEC_W'(1);
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.abcde_out   = idx;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.mask        = mask;
  assign bus.count       = count;
  assign bus.first_valid = first_valid;
  assign bus.first_idx   = first_idx;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed and randomized scans of minterm_scanner against a truth-table
// model of the external expression and of the scan results.
module tb_minterm_scanner;
  import minterm_scanner_pkg::*;

  localparam int S   = 2;
  localparam int LAT = 32 * (S + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  // 0: expression under test, 1: tied 0, 2: tied 1, 3: random truth table
  int          mode = 0;
  logic [31:0] tt   = '0;

  minterm_scanner_if sif ();

  minterm_scanner #(.SETTLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  function automatic logic ext_y(input int m, input logic [4:0] v);
    logic a, b, c, d, e;
    {a, b, c, d, e} = v;
    case (m)
      0:       return (a & ~b & ~c) | (a & b & e) | (~b & ~c) | (c & ~d);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return tt[v];
    endcase
  endfunction

  assign sif.y_in = ext_y(mode, sif.abcde_out);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask(input int m, input logic tgt);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (ext_y(m, 5'(i)) == tgt);
    return r;
  endfunction

  task automatic check_results(input string tag, input int m, input logic tgt);
    logic [31:0] em;
    int          ecount;
    int          efi;
    logic        efv;
    em     = model_mask(m, tgt);
    ecount = 0;
    efv    = 1'b0;
    efi    = 0;
    for (int i = 31; i >= 0; i--) begin
      if (em[i]) begin
        ecount++;
        efv = 1'b1;
        efi = i;
      end
    end
    check({tag, "_mask"},  sif.mask, em);
    check({tag, "_count"}, 32'(sif.count), 32'(ecount));
    check({tag, "_fv"},    32'(sif.first_valid), 32'(efv));
    check({tag, "_fi"},    32'(sif.first_idx), 32'(efi));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_abcde"}, 32'(sif.abcde_out), 32'd0);
    check({tag, "_busy"},  32'(sif.busy), 32'd0);
    check({tag, "_done"},  32'(sif.done), 32'd0);
    check({tag, "_mask"},  sif.mask, 32'd0);
    check({tag, "_count"}, 32'(sif.count), 32'd0);
    check({tag, "_fv"},    32'(sif.first_valid), 32'd0);
    check({tag, "_fi"},    32'(sif.first_idx), 32'd0);
    check({tag, "_state"}, 32'(sif.dbg_state), 32'(IDLE));
  endtask

  // Starts at a negedge; returns at the negedge after the accepting edge (cycle 1).
  task automatic start_scan(input logic tgt);
    sif.start  = 1'b1;
    sif.target = tgt;
    @(negedge clk);
    sif.start  = 1'b0;
  endtask

  // Follows a scan from cycle 1 until done; optionally re-pulses start at idx rp.
  task automatic wait_scan(input string tag, input logic tgt, input int rp);
    int cyc;
    int seq_bad;
    bit pulsed;
    cyc     = 1;
    seq_bad = 0;
    pulsed  = 0;
    while (sif.done !== 1'b1 && cyc < 400) begin
      if (sif.abcde_out !== 5'((cyc - 1) / (S + 1))) seq_bad++;
      if (sif.busy !== 1'b1 || sif.dbg_state !== HOLD) seq_bad++;
      if (rp >= 0 && !pulsed && int'(sif.abcde_out) == rp) begin
        sif.start  = 1'b1;
        sif.target = ~tgt;
        pulsed     = 1;
      end
      @(negedge clk);
      sif.start = 1'b0;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    check({tag, "_walk"},    32'(seq_bad), 32'd0);
    check({tag, "_dbusy"},   32'(sif.busy), 32'd0);
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(sif.done), 32'd0);
    check({tag, "_hold"},  32'(sif.abcde_out), 32'd31);
  endtask

  initial begin
    int          guard;
    int          done_seen;
    logic        rt;
    logic [31:0] held_mask;

    sif.start  = 1'b1;
    sif.target = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst       = 1'b0;
    sif.start = 1'b0;
    @(negedge clk);

    // Expression, target 1
    mode = 0;
    start_scan(1'b1);
    wait_scan("t1", 1'b1, -1);
    check_results("t1", 0, 1'b1);
    check("t1_mask_const", sif.mask, 32'hBA3F303F);
    held_mask = sif.mask;
    after_done("t1");
    repeat (5) @(negedge clk);
    check("idle_mask_hold", sif.mask, held_mask);
    check("idle_abcde", 32'(sif.abcde_out), 32'd31);

    // Expression, target 0
    start_scan(1'b0);
    wait_scan("t0", 1'b0, -1);
    check_results("t0", 0, 1'b0);
    check("t0_mask_const", sif.mask, 32'h45C0CFC0);
    after_done("t0");

    // Tied inputs
    mode = 1;
    start_scan(1'b1);
    wait_scan("tie0", 1'b1, -1);
    check_results("tie0", 1, 1'b1);
    after_done("tie0");
    mode = 2;
    start_scan(1'b1);
    wait_scan("tie1", 1'b1, -1);
    check_results("tie1", 2, 1'b1);
    after_done("tie1");

    // Reset at idx 10 aborts with no done pulse
    mode = 0;
    start_scan(1'b1);
    guard = 0;
    while (sif.abcde_out != 5'd10 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reach10", 32'(sif.abcde_out), 32'd10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("abort");
    done_seen = 0;
    repeat (120) begin
      @(negedge clk);
      if (sif.done === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    start_scan(1'b1);
    wait_scan("restart", 1'b1, -1);
    check_results("restart", 0, 1'b1);
    after_done("restart");

    // start re-pulsed mid-scan is ignored
    start_scan(1'b1);
    wait_scan("repulse", 1'b1, 5);
    check_results("repulse", 0, 1'b1);

    // start held in DONE cycle restarts immediately with cleared results
    sif.start  = 1'b1;
    sif.target = 1'b0;
    @(negedge clk);
    sif.start  = 1'b0;
    check("chain_busy",  32'(sif.busy), 32'd1);
    check("chain_mask",  sif.mask, 32'd0);
    check("chain_count", 32'(sif.count), 32'd0);
    check("chain_abcde", 32'(sif.abcde_out), 32'd0);
    check("chain_done",  32'(sif.done), 32'd0);
    wait_scan("chain", 1'b0, -1);
    check_results("chain", 0, 1'b0);
    after_done("chain");

    // Randomized truth tables
    mode = 3;
    for (int k = 0; k < 4; k++) begin
      tt = $urandom();
      rt = 1'($urandom_range(0, 1));
      start_scan(rt);
      wait_scan("rand", rt, -1);
      check_results("rand", 3, rt);
      after_done("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/minterm_scanner.md
MINTERM_SCANNER -- requirements
Module: minterm_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: extra cycles each input vector is held before y_in is sampled; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle scan request; accepted only in IDLE or DONE.
REQ-005 target  input  1  y_in value counted as a match; latched when start is accepted.
REQ-006 y_in  input  1  output of the external 5-input expression under test.
REQ-007 abcde_out  output  5  drive vector {A,B,C,D,E}; bit4=A, bit0=E.
REQ-008 busy  output  1  high while scanning.
REQ-009 done  output  1  one-cycle pulse when the scan completes.
REQ-010 mask  output  32  mask[i]=1 when vector i produced y_in==target.
REQ-011 count  output  6  number of set bits in mask, 0..32.
REQ-012 first_valid  output  1  at least one match found; first_idx  output  5  lowest matching index.

Function
REQ-013 FSM states: IDLE, HOLD, DONE.
REQ-014 IDLE or DONE with start=1 -> HOLD; idx=0, hold counter=0, mask=0, count=0, first_valid=0, first_idx=0, target latched.
REQ-015 In HOLD, abcde_out equals idx from the cycle after acceptance; busy=1.
REQ-016 Each vector is held for SETTLE_CYCLES+1 cycles; y_in is sampled on the last of those cycles.
REQ-017 On sample: mask[idx] set if y_in==target; count incremented if matched; first_idx=idx and first_valid=1 on the first match only.
REQ-018 After sample with idx<31: idx increments by 1 and hold counter clears; with idx==31: move to DONE; idx does not wrap.
REQ-019 DONE lasts one cycle: done=1, busy=0; then IDLE unless start=1 in that cycle.
REQ-020 Total latency: start accepted at edge 0 -> done high in cycle 32*(SETTLE_CYCLES+1)+1.
REQ-021 start while in HOLD is ignored; scan continues undisturbed.
REQ-022 mask, count, first_valid and first_idx hold their values in IDLE until the next accepted start.
REQ-023 abcde_out holds 5'd31 in DONE and IDLE after a scan.
REQ-024 count cannot overflow: 6 bits cover 32 matches.

Reset
REQ-025 rst=1 at an edge -> IDLE, abcde_out=0, busy=0, done=0, mask=0, count=0, first_valid=0, first_idx=0, target=0; this takes priority over start.
REQ-026 rst asserted mid-scan aborts the scan without a done pulse; a new start after rst deasserts begins from idx 0.

Structure
REQ-027 Package minterm_scanner_pkg holds the state enum (IDLE, HOLD, DONE), NUM_VEC=32, VEC_W=5 and CNT_W=6.
REQ-028 Single module, no sub-module; the expression under test stays outside the block and connects through abcde_out and y_in.

Verification
REQ-029 Bench drives y_in combinationally from Y = A·~B·~C + A·B·E + ~B·~C + C·~D, with SETTLE_CYCLES=2 and zero-delay gates.
REQ-030 Target=1 scan -> done in cycle 97; mask=0xBA3F303F, count=19, first_valid=1, first_idx=0.
REQ-031 Target=0 scan -> mask=0x45C0CFC0, count=13, first_idx=6.
REQ-032 y_in tied 0, target=1 -> mask=0, count=0, first_valid=0; y_in tied 1 -> mask=0xFFFFFFFF, count=32.
REQ-033 rst pulsed at idx=10, then start -> no done pulse before the restart; all outputs 0 after rst; the full second scan gives the results in REQ-030.
REQ-034 start re-pulsed at idx=5 -> ignored, done still in cycle 97; start held high in the DONE cycle -> a new scan begins on the next edge with mask cleared.
